add16_nibble_serial: RTL and testbench



---
 rtl/add16_nibble_serial_if.sv | 7 +
 rtl/add16_nibble_serial.sv | 65 ++++++
 tb/tb_add16_nibble_serial.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/add16_nibble_serial_if.sv
// add16_nibble_serial_if: start/busy/done handshake and operand/result bus for the serial adder.
interface add16_nibble_serial_if #(parameter int WIDTH = 16);
    logic start, cin, busy, done, cout, ovf;
    logic [WIDTH-1:0] a, b, sum;
    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave (input start, a, b, cin, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/add16_nibble_serial.sv
// add16_nibble_serial: WIDTH-bit adder iterating one nibble per cycle through a single 4-bit ripple slice.
module add_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = 5'(a) + 5'(b) + 5'(cin);
endmodule

module add16_nibble_serial #(parameter int WIDTH = 16) (
    input logic clk,
    input logic rst,
    add16_nibble_serial_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int KW = NIB > 1 ? $clog2(NIB) : 1;
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, next;
    logic [WIDTH-1:0] a_reg, b_reg, sum_r;
    logic [KW-1:0] k;
    logic carry, cout_r, ovf_r, nc, last;
    logic [3:0] an, bn, ns;
    assign an = a_reg[4*int'(k) +: 4];
    assign bn = b_reg[4*int'(k) +: 4];
    assign last = k == KW'(NIB - 1);
    add_4 u_add (.a(an), .b(bn), .cin(carry), .sum(ns), .cout(nc));
    always_ff @(posedge clk)
        state <= rst ? IDLE : next;
    always_comb begin
        next = state == IDLE ? (bus.start ? RUN : IDLE) : state == RUN ? (last ? FIN : RUN) : IDLE;
        bus.busy = state == RUN;
        bus.done = state == FIN;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            k <= '0;
            sum_r <= '0;
            cout_r <= 1'b0;
            ovf_r <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            a_reg <= bus.a;
            b_reg <= bus.b;
            carry <= bus.cin;
            k <= '0;
            sum_r <= '0;
        end else if (state == RUN) begin
            sum_r[4*int'(k) +: 4] <= ns;
            carry <= nc;
            k <= last ? k : k + KW'(1);
            if (last) begin
                cout_r <= nc;
                // carry into the MSB is a^b^sum at that bit; xor with carry out flags signed overflow
                ovf_r <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ ns[3] ^ nc;
            end
        end
    end
    assign bus.sum = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf = ovf_r;
endmodule

// File: tb/tb_add16_nibble_serial.sv
// tb_add16_nibble_serial: scoreboard bench for the nibble-serial adder and its handshake.
module tb_add16_nibble_serial;
    typedef struct {logic [15:0] s; logic c; logic v;} res_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic prev_busy = 1'b0;
    res_t q[$];
    int rises[$];
    add16_nibble_serial_if #(.WIDTH(16)) bus ();
    add16_nibble_serial #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] t;
        t = {1'b0, a} + {1'b0, b} + {16'b0, c};
        model.s = t[15:0];
        model.c = t[16];
        model.v = (a[15] == b[15]) && (t[15] != a[15]);
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.busy && !prev_busy) rises.push_back(cyc);
        prev_busy = bus.busy;
        if (bus.done) begin
            res_t r;
            done_cnt++;
            if (q.size() == 0) check("spurious_done", 1, 0);
            else begin
                r = q.pop_front();
                check("sum", bus.sum, r.s);
                check("cout", bus.cout, r.c);
                check("ovf", bus.ovf, r.v);
            end
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c);
        int n = 0;
        int t = 0;
        logic [3:0] p;
        p = a[3:0] + b[3:0] + {3'b0, c};
        @(negedge clk);
        bus.a = a; bus.b = b; bus.cin = c; bus.start = 1'b1;
        q.push_back(model(a, b, c));
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.done && t < 20) begin
            if (bus.busy) n++;
            if (t == 1) check("partial", bus.sum, {12'h0, p});
            @(negedge clk);
            t++;
        end
        check("done_seen", t < 20, 1);
        check("busy_cycles", n, 4);
        @(negedge clk);
        check("done_one_cycle", bus.done, 0);
    endtask

    initial begin
        int t;
        int d0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_cout", bus.cout, 0);
        check("rst_ovf", bus.ovf, 0);
        bus.start = 1'b1; bus.a = 16'h1111;
        @(negedge clk);
        bus.start = 1'b0; rst = 1'b0;
        check("rst_beats_start", bus.busy, 0);
        run_op(16'h1234, 16'h4321, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b1);
        run_op(16'h7FFF, 16'h0001, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0);
        // abort mid-run: outputs clear and no done pulse follows
        d0 = done_cnt;
        @(negedge clk);
        bus.a = 16'h1234; bus.b = 16'h1111; bus.cin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_sum", bus.sum, 0);
        check("abort_cout", bus.cout, 0);
        check("abort_ovf", bus.ovf, 0);
        repeat (8) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        run_op(16'h0002, 16'h0003, 1'b1);
        // start while busy is ignored
        d0 = done_cnt;
        @(negedge clk);
        bus.a = 16'h0F0F; bus.b = 16'h00F1; bus.cin = 1'b0; bus.start = 1'b1;
        q.push_back(model(16'h0F0F, 16'h00F1, 1'b0));
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'hFFFF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check("single_done", done_cnt - d0, 1);
        // back-to-back with start held high
        d0 = done_cnt;
        rises.delete();
        bus.a = 16'h0001; bus.b = 16'h0001; bus.cin = 1'b0;
        repeat (3) q.push_back(model(16'h0001, 16'h0001, 1'b0));
        bus.start = 1'b1;
        t = 0;
        while (rises.size() < 3 && t < 40) begin
            @(negedge clk);
            t++;
        end
        bus.start = 1'b0;
        check("b2b_accepts", rises.size(), 3);
        if (rises.size() >= 3) begin
            check("b2b_gap1", rises[1] - rises[0], 6);
            check("b2b_gap2", rises[2] - rises[1], 6);
        end
        t = 0;
        while (q.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        repeat (8) @(negedge clk);
        check("b2b_dones", done_cnt - d0, 3);
        check("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
